addsub_arbiter: RTL and testbench

- Shares one 16-bit saturating add/sub datapath (CLA_16bit_AddSub) between two requesters, e.g. the ALU issue path and the address/offset path.
- Arbitrates with a round-robin or fixed-priority policy, latches the granted operands and sequences one operation through the datapath.
- Returns a registered result, overflow flag and requester ID over a valid/ready response channel.

---
 rtl/addsub_arbiter_if.sv | 37 +++
 rtl/addsub_arbiter.sv | 122 ++++++++++++
 tb/tb_addsub_arbiter.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/addsub_arbiter_if.sv
// addsub_arbiter_if: request/response bundle between two requesters, a consumer and the shared add/sub unit.
// Requester N drives reqN_valid/a/b/sub and observes reqN_ready.
// The consumer observes rsp_valid/id/sum/ovf and drives rsp_ready.
// The master modport is the requester/consumer side; the slave modport is the arbiter side.
interface addsub_arbiter_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [15:0] req0_a;
    logic [15:0] req0_b;
    logic        req0_sub;
    logic        req1_valid;
    logic        req1_ready;
    logic [15:0] req1_a;
    logic [15:0] req1_b;
    logic        req1_sub;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [15:0] rsp_sum;
    logic        rsp_ovf;

    modport master (
        output req0_valid, req0_a, req0_b, req0_sub,
        output req1_valid, req1_a, req1_b, req1_sub,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_sum, rsp_ovf
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_sub,
        input  req1_valid, req1_a, req1_b, req1_sub,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_sum, rsp_ovf
    );
endinterface

// File: rtl/addsub_arbiter.sv
// addsub_arbiter: two requesters share one saturating 16-bit add/sub datapath through an arbiter.
// Ports: clk, rst (sync, active-high), bus (addsub_arbiter_if.slave: request and response channels),
// busy (high whenever the FSM is not IDLE).
// PRIO_FIXED=0 selects round-robin; PRIO_FIXED=1 lets requester 0 win every contention.

// cla_16bit_addsub: 16-bit two's-complement add/sub with saturation.
// Ports: a, b operands; sub=1 computes a-b; sum is the saturated result.
module cla_16bit_addsub (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        sub,
    output logic [15:0] sum
);
    logic [15:0] bx, g, p, raw;
    logic [16:0] c;
    logic [3:0]  gg, pg;
    logic        ovf;

    assign bx = b ^ {16{sub}};
    assign g  = a & bx;
    assign p  = a ^ bx;

    // Ripple inside each 4-bit group; group carry-out comes from the group generate/propagate terms.
    always_comb begin
        c    = '0;
        gg   = '0;
        pg   = '0;
        c[0] = sub;
        for (int j = 0; j < 4; j++) begin
            pg[j] = &p[4*j +: 4];
            gg[j] = g[4*j+3] | (p[4*j+3] & (g[4*j+2] | (p[4*j+2] & (g[4*j+1] | (p[4*j+1] & g[4*j])))));
            for (int k = 0; k < 3; k++)
                c[4*j+k+1] = g[4*j+k] | (p[4*j+k] & c[4*j+k]);
            c[4*j+4] = gg[j] | (pg[j] & c[4*j]);
        end
    end

    assign raw = p ^ c[15:0];
    // Signed overflow iff carry into and out of the sign bit differ; carry-out tells the direction.
    assign ovf = c[16] ^ c[15];
    assign sum = ovf ? (c[16] ? 16'h8000 : 16'h7fff) : raw;
endmodule

module addsub_arbiter #(
    parameter bit PRIO_FIXED = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    addsub_arbiter_if.slave      bus,
    output logic                 busy
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t      state, state_d;
    logic        last_grant;
    logic [15:0] op_a, op_b;
    logic        op_sub, op_id;
    logic        sel;
    logic [15:0] dp_sum;
    logic [16:0] wide;

    cla_16bit_addsub u_dp (
        .a   (op_a),
        .b   (op_b),
        .sub (op_sub),
        .sum (dp_sum)
    );

    // Exact 17-bit result; its top two bits disagree exactly when the value leaves the 16-bit range.
    assign wide = op_sub ? {op_a[15], op_a} - {op_b[15], op_b} : {op_a[15], op_a} + {op_b[15], op_b};

    assign sel  = (bus.req0_valid & bus.req1_valid) ? (PRIO_FIXED ? 1'b0 : ~last_grant) : bus.req1_valid;
    assign busy = state != IDLE;

    always_comb begin
        state_d        = state;
        bus.req0_ready = 1'b0;
        bus.req1_ready = 1'b0;
        case (state)
            IDLE: begin
                bus.req0_ready = bus.req0_valid & ~sel;
                bus.req1_ready = bus.req1_valid & sel;
                state_d        = (bus.req0_valid | bus.req1_valid) ? EXEC : IDLE;
            end
            EXEC:    state_d = RESP;
            RESP:    state_d = bus.rsp_ready ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            last_grant    <= 1'b1;
            op_a          <= '0;
            op_b          <= '0;
            op_sub        <= 1'b0;
            op_id         <= 1'b0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_id    <= 1'b0;
            bus.rsp_sum   <= '0;
            bus.rsp_ovf   <= 1'b0;
        end else begin
            state <= state_d;
            if (state == IDLE && (bus.req0_ready | bus.req1_ready)) begin
                op_a       <= sel ? bus.req1_a : bus.req0_a;
                op_b       <= sel ? bus.req1_b : bus.req0_b;
                op_sub     <= sel ? bus.req1_sub : bus.req0_sub;
                op_id      <= sel;
                last_grant <= sel;
            end
            if (state == EXEC) begin
                bus.rsp_sum   <= dp_sum;
                bus.rsp_id    <= op_id;
                bus.rsp_ovf   <= wide[16] ^ wide[15];
                bus.rsp_valid <= 1'b1;
            end
            if (state == RESP && bus.rsp_ready)
                bus.rsp_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_addsub_arbiter.sv
// tb_addsub_arbiter: directed checks of both arbitration policies of addsub_arbiter.
module tb_addsub_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy0, busy1;
    int   checks = 0;
    int   failures = 0;

    localparam logic [15:0] SA [4] = '{16'h7fff, 16'h8000, 16'h0005, 16'h8000};
    localparam logic [15:0] SB [4] = '{16'h0001, 16'h0001, 16'h0007, 16'h8000};
    localparam logic        SS [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    localparam logic [15:0] SE [4] = '{16'h7fff, 16'h8000, 16'hfffe, 16'h8000};
    localparam logic        SO [4] = '{1'b1, 1'b1, 1'b0, 1'b1};

    addsub_arbiter_if b0 ();
    addsub_arbiter_if b1 ();

    addsub_arbiter #(.PRIO_FIXED(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(b0), .busy(busy0));
    addsub_arbiter #(.PRIO_FIXED(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(b1), .busy(busy1));

    always #5 clk = ~clk;

    task idle_inputs;
        b0.req0_valid = 0; b0.req0_a = 0; b0.req0_b = 0; b0.req0_sub = 0;
        b0.req1_valid = 0; b0.req1_a = 0; b0.req1_b = 0; b0.req1_sub = 0;
        b0.rsp_ready = 1;
        b1.req0_valid = 0; b1.req0_a = 0; b1.req0_b = 0; b1.req0_sub = 0;
        b1.req1_valid = 0; b1.req1_a = 0; b1.req1_b = 0; b1.req1_sub = 0;
        b1.rsp_ready = 1;
    endtask

    task test_reset;
        idle_inputs();
        rst = 1;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (b0.rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0", b0.rsp_valid); end
        checks++; if (b0.rsp_sum !== 16'h0000) begin failures++; $display("FAIL reset_rsp_sum got=%h exp=0000", b0.rsp_sum); end
        checks++; if (b0.rsp_id !== 1'b0) begin failures++; $display("FAIL reset_rsp_id got=%b exp=0", b0.rsp_id); end
        checks++; if (b0.rsp_ovf !== 1'b0) begin failures++; $display("FAIL reset_rsp_ovf got=%b exp=0", b0.rsp_ovf); end
        checks++; if (busy0 !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy0); end
        checks++; if (b0.req0_ready !== 1'b0 || b0.req1_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b%b exp=00", b0.req0_ready, b0.req1_ready); end
        checks++; if (b1.rsp_valid !== 1'b0 || busy1 !== 1'b0) begin failures++; $display("FAIL reset_fixed got=%b%b exp=00", b1.rsp_valid, busy1); end
        rst = 0;
    endtask

    task test_simple_add;
        @(negedge clk);
        b0.req0_valid = 1; b0.req0_a = 16'h0003; b0.req0_b = 16'h0004; b0.req0_sub = 0;
        #1;
        checks++; if (b0.req0_ready !== 1'b1 || b0.req1_ready !== 1'b0) begin failures++; $display("FAIL add_ready got=%b%b exp=10", b0.req0_ready, b0.req1_ready); end
        @(negedge clk);
        b0.req0_valid = 0;
        #1;
        checks++; if (busy0 !== 1'b1 || b0.rsp_valid !== 1'b0) begin failures++; $display("FAIL add_exec got busy=%b valid=%b exp busy=1 valid=0", busy0, b0.rsp_valid); end
        @(negedge clk);
        #1;
        checks++; if (b0.rsp_valid !== 1'b1) begin failures++; $display("FAIL add_rsp_valid got=%b exp=1", b0.rsp_valid); end
        checks++; if (b0.rsp_sum !== 16'h0007) begin failures++; $display("FAIL add_sum got=%h exp=0007", b0.rsp_sum); end
        checks++; if (b0.rsp_ovf !== 1'b0 || b0.rsp_id !== 1'b0) begin failures++; $display("FAIL add_ovf_id got=%b%b exp=00", b0.rsp_ovf, b0.rsp_id); end
        @(negedge clk);
        #1;
        checks++; if (b0.rsp_valid !== 1'b0 || busy0 !== 1'b0) begin failures++; $display("FAIL add_done got valid=%b busy=%b exp 0 0", b0.rsp_valid, busy0); end
    endtask

    task test_saturation;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            b0.req1_valid = 1; b0.req1_a = SA[i]; b0.req1_b = SB[i]; b0.req1_sub = SS[i];
            #1;
            checks++; if (b0.req1_ready !== 1'b1 || b0.req0_ready !== 1'b0) begin failures++; $display("FAIL sat%0d_ready got=%b%b exp=01", i, b0.req0_ready, b0.req1_ready); end
            @(negedge clk);
            b0.req1_valid = 0;
            @(negedge clk);
            #1;
            checks++; if (b0.rsp_valid !== 1'b1 || b0.rsp_id !== 1'b1) begin failures++; $display("FAIL sat%0d_valid_id got=%b%b exp=11", i, b0.rsp_valid, b0.rsp_id); end
            checks++; if (b0.rsp_sum !== SE[i]) begin failures++; $display("FAIL sat%0d_sum got=%h exp=%h", i, b0.rsp_sum, SE[i]); end
            checks++; if (b0.rsp_ovf !== SO[i]) begin failures++; $display("FAIL sat%0d_ovf got=%b exp=%b", i, b0.rsp_ovf, SO[i]); end
        end
        @(negedge clk);
    endtask

    task test_contention;
        logic exp_id;
        @(negedge clk);
        rst = 1;
        b0.req0_valid = 1; b0.req0_a = 16'h0010; b0.req0_b = 16'h0001; b0.req0_sub = 0;
        b0.req1_valid = 1; b0.req1_a = 16'h0100; b0.req1_b = 16'h0030; b0.req1_sub = 1;
        b1.req0_valid = 1; b1.req0_a = 16'h0010; b1.req0_b = 16'h0001; b1.req0_sub = 0;
        b1.req1_valid = 1; b1.req1_a = 16'h0100; b1.req1_b = 16'h0030; b1.req1_sub = 1;
        @(negedge clk);
        rst = 0;
        for (int i = 0; i < 4; i++) begin
            exp_id = (i % 2) == 1;
            #1;
            checks++; if (b0.req0_ready !== ~exp_id || b0.req1_ready !== exp_id) begin failures++; $display("FAIL rr%0d_grant got=%b%b exp_id=%b", i, b0.req0_ready, b0.req1_ready, exp_id); end
            checks++; if (b1.req0_ready !== 1'b1 || b1.req1_ready !== 1'b0) begin failures++; $display("FAIL fix%0d_grant got=%b%b exp=10", i, b1.req0_ready, b1.req1_ready); end
            @(negedge clk);
            #1;
            checks++; if (b1.req1_ready !== 1'b0) begin failures++; $display("FAIL fix%0d_exec_ready got=%b exp=0", i, b1.req1_ready); end
            @(negedge clk);
            #1;
            checks++; if (b0.rsp_valid !== 1'b1 || b0.rsp_id !== exp_id) begin failures++; $display("FAIL rr%0d_rsp got valid=%b id=%b exp 1 %b", i, b0.rsp_valid, b0.rsp_id, exp_id); end
            checks++; if (b0.rsp_sum !== (exp_id ? 16'h00d0 : 16'h0011)) begin failures++; $display("FAIL rr%0d_sum got=%h exp=%h", i, b0.rsp_sum, exp_id ? 16'h00d0 : 16'h0011); end
            checks++; if (b1.rsp_valid !== 1'b1 || b1.rsp_id !== 1'b0 || b1.rsp_sum !== 16'h0011) begin failures++; $display("FAIL fix%0d_rsp got valid=%b id=%b sum=%h exp 1 0 0011", i, b1.rsp_valid, b1.rsp_id, b1.rsp_sum); end
            @(negedge clk);
        end
        idle_inputs();
    endtask

    task test_backpressure;
        @(negedge clk);
        b0.rsp_ready = 0;
        b0.req0_valid = 1; b0.req0_a = 16'h0100; b0.req0_b = 16'h0020; b0.req0_sub = 0;
        #1;
        checks++; if (b0.req0_ready !== 1'b1) begin failures++; $display("FAIL bp_accept got=%b exp=1", b0.req0_ready); end
        @(negedge clk);
        b0.req0_valid = 0;
        b0.req1_valid = 1; b0.req1_a = 16'h0002; b0.req1_b = 16'h0003; b0.req1_sub = 0;
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            #1;
            checks++; if (b0.rsp_valid !== 1'b1 || b0.rsp_sum !== 16'h0120 || b0.rsp_id !== 1'b0 || b0.rsp_ovf !== 1'b0) begin failures++; $display("FAIL bp%0d_hold got valid=%b sum=%h id=%b ovf=%b exp 1 0120 0 0", k, b0.rsp_valid, b0.rsp_sum, b0.rsp_id, b0.rsp_ovf); end
            checks++; if (busy0 !== 1'b1 || b0.req0_ready !== 1'b0 || b0.req1_ready !== 1'b0) begin failures++; $display("FAIL bp%0d_block got busy=%b ready=%b%b exp 1 00", k, busy0, b0.req0_ready, b0.req1_ready); end
            if (k < 4) @(negedge clk);
        end
        b0.rsp_ready = 1;
        @(negedge clk);
        #1;
        checks++; if (b0.rsp_valid !== 1'b0 || busy0 !== 1'b0) begin failures++; $display("FAIL bp_release got valid=%b busy=%b exp 0 0", b0.rsp_valid, busy0); end
        checks++; if (b0.rsp_sum !== 16'h0120) begin failures++; $display("FAIL bp_keep_sum got=%h exp=0120", b0.rsp_sum); end
        checks++; if (b0.req1_ready !== 1'b1) begin failures++; $display("FAIL bp_next_ready got=%b exp=1", b0.req1_ready); end
        @(negedge clk);
        b0.req1_valid = 0;
        @(negedge clk);
        #1;
        checks++; if (b0.rsp_valid !== 1'b1 || b0.rsp_sum !== 16'h0005 || b0.rsp_id !== 1'b1) begin failures++; $display("FAIL bp_next_rsp got valid=%b sum=%h id=%b exp 1 0005 1", b0.rsp_valid, b0.rsp_sum, b0.rsp_id); end
        @(negedge clk);
    endtask

    task test_reset_exec;
        @(negedge clk);
        b0.req0_valid = 1; b0.req0_a = 16'h1234; b0.req0_b = 16'h0001; b0.req0_sub = 0;
        #1;
        checks++; if (b0.req0_ready !== 1'b1) begin failures++; $display("FAIL rx_accept got=%b exp=1", b0.req0_ready); end
        @(negedge clk);
        b0.req0_valid = 0;
        #1;
        checks++; if (busy0 !== 1'b1) begin failures++; $display("FAIL rx_exec_busy got=%b exp=1", busy0); end
        rst = 1;
        @(negedge clk);
        rst = 0;
        #1;
        checks++; if (b0.rsp_valid !== 1'b0 || busy0 !== 1'b0) begin failures++; $display("FAIL rx_state got valid=%b busy=%b exp 0 0", b0.rsp_valid, busy0); end
        checks++; if (b0.rsp_sum !== 16'h0000) begin failures++; $display("FAIL rx_sum got=%h exp=0000", b0.rsp_sum); end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            checks++; if (b0.rsp_valid !== 1'b0) begin failures++; $display("FAIL rx_no_rsp%0d got=%b exp=0", k, b0.rsp_valid); end
        end
    endtask

    initial begin
        test_reset();
        test_simple_add();
        test_saturation();
        test_contention();
        test_backpressure();
        test_reset_exec();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
